// File: rtl/mvm_uart_frame_ctrl.sv
// Command-framed byte-stream controller between the UART byte layer and the
// matrix-vector multiplier: holds a persistent K, runs X-only frames, replies with Y bytes plus an XOR checksum.
module mvm_uart_frame_ctrl #(
  parameter int R       = 8,
  parameter int C       = 8,
  parameter int W_X     = 8,
  parameter int W_K     = 8,
  parameter int W_Y_OUT = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_byte_valid,
  input  logic [7:0]                            s_byte_data,
  output logic                                  m_kx_valid,
  input  logic                                  m_kx_ready,
  output logic [R*C*W_K+C*W_X-1:0]              m_kx_data,
  input  logic                                  s_y_valid,
  output logic                                  s_y_ready,
  input  logic [R*(W_X+W_K+$clog2(C))-1:0]      s_y_data,
  output logic                                  m_byte_valid,
  input  logic                                  m_byte_ready,
  output logic [7:0]                            m_byte_data,
  output logic                                  err_header,
  output logic                                  err_overrun
);

  localparam int W_Y   = W_X + W_K + $clog2(C);
  localparam int W_KF  = R * C * W_K;
  localparam int W_XF  = C * W_X;
  localparam int N_K   = W_KF / 8;
  localparam int N_X   = W_XF / 8;
  localparam int N_Y   = R * W_Y_OUT / 8;
  localparam int W_E   = (W_Y_OUT > W_Y) ? W_Y_OUT : W_Y;
  localparam int MAXN  = (N_K > N_X) ? ((N_K > N_Y) ? N_K : N_Y) : ((N_X > N_Y) ? N_X : N_Y);
  localparam int CNT_W = $clog2(MAXN + 1);

  localparam logic [CNT_W-1:0] LAST_K  = CNT_W'(N_K - 1);
  localparam logic [CNT_W-1:0] LAST_X  = CNT_W'(N_X - 1);
  localparam logic [CNT_W-1:0] LAST_YD = CNT_W'(N_Y - 1);
  localparam logic [CNT_W-1:0] LAST_Y  = CNT_W'(N_Y);

  typedef enum logic [2:0] {
    S_IDLE, S_RX_K, S_RX_X, S_ISSUE, S_WAIT_Y, S_TX, S_ACK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load_only;
  logic [W_KF-1:0]  k_reg;
  logic [W_XF-1:0]  x_reg;
  logic [W_XF-1:0]  x_next;
  logic [N_Y*8-1:0] y_conv;
  logic [N_Y*8-1:0] y_buf;
  logic [W_E-1:0]   y_ext;
  logic [7:0]       csum;
  logic [7:0]       csum_next;

  // Each y[r] is widened with its sign (or cut down when W_Y_OUT is narrower) and the checksum is precomputed for capture.
  always_comb begin
    x_next = x_reg;
    x_next[8*int'(cnt) +: 8] = s_byte_data;
    y_conv    = '0;
    y_ext     = '0;
    csum_next = '0;
    for (int r = 0; r < R; r++) begin
      y_ext = W_E'($signed(s_y_data[W_Y*r +: W_Y]));
      y_conv[W_Y_OUT*r +: W_Y_OUT] = y_ext[W_Y_OUT-1:0];
    end
    for (int i = 0; i < N_Y; i++) begin
      csum_next = csum_next ^ y_conv[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      load_only    <= 1'b0;
      k_reg        <= '0;
      x_reg        <= '0;
      y_buf        <= '0;
      csum         <= '0;
      m_kx_valid   <= 1'b0;
      m_kx_data    <= '0;
      s_y_ready    <= 1'b0;
      m_byte_valid <= 1'b0;
      m_byte_data  <= '0;
      err_header   <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      err_header  <= 1'b0;
      err_overrun <= 1'b0;
      case (state)
        S_IDLE: begin
          if (s_byte_valid) begin
            cnt <= '0;
            case (s_byte_data)
              8'hA0: begin state <= S_RX_K; load_only <= 1'b0; end
              8'hA1: state <= S_RX_X;
              8'hA2: begin state <= S_RX_K; load_only <= 1'b1; end
              default: err_header <= 1'b1;
            endcase
          end
        end
        S_RX_K: begin
          if (s_byte_valid) begin
            k_reg[8*int'(cnt) +: 8] <= s_byte_data;
            if (cnt == LAST_K) begin
              cnt <= '0;
              if (load_only) begin
                state        <= S_ACK;
                m_byte_valid <= 1'b1;
                m_byte_data  <= 8'hA2;
              end else begin
                state <= S_RX_X;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_RX_X: begin
          if (s_byte_valid) begin
            x_reg <= x_next;
            if (cnt == LAST_X) begin
              cnt        <= '0;
              state      <= S_ISSUE;
              m_kx_valid <= 1'b1;
              m_kx_data  <= {x_next, k_reg};
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (m_kx_ready) begin
            m_kx_valid <= 1'b0;
            s_y_ready  <= 1'b1;
            state      <= S_WAIT_Y;
          end
        end
        S_WAIT_Y: begin
          if (s_y_valid) begin
            s_y_ready    <= 1'b0;
            y_buf        <= y_conv >> 8;
            csum         <= csum_next;
            m_byte_valid <= 1'b1;
            m_byte_data  <= y_conv[7:0];
            cnt          <= '0;
            state        <= S_TX;
          end
        end
        // cnt is the index of the byte on the bus; index N_Y is the checksum.
        S_TX: begin
          if (m_byte_ready) begin
            if (cnt == LAST_Y) begin
              m_byte_valid <= 1'b0;
              cnt          <= '0;
              state        <= S_IDLE;
            end else if (cnt == LAST_YD) begin
              m_byte_data <= csum;
              cnt         <= cnt + 1'b1;
            end else begin
              m_byte_data <= y_buf[7:0];
              y_buf       <= y_buf >> 8;
              cnt         <= cnt + 1'b1;
            end
          end
        end
        S_ACK: begin
          if (m_byte_ready) begin
            m_byte_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (s_byte_valid && (state == S_ISSUE || state == S_WAIT_Y || state == S_TX || state == S_ACK)) begin
        err_overrun <= 1'b1;
      end
    end
  end

endmodule
